// File: rtl/block_checker.sv
// Streaming begin/end nesting checker: one ASCII byte per clock, case-insensitive,
// result high while the text so far is balanced and no unmatched "end" was confirmed.
module block_checker #(
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in,
   output logic       result
);

   typedef enum logic [3:0] {
      S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
   } state_t;

   localparam logic signed [CNT_W-1:0] DEPTH_MAX = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic signed [CNT_W-1:0] DEPTH_MIN = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic signed [CNT_W-1:0] DEPTH_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Declaration initialisers give the same state at power-up as after reset.
   state_t                   r_state = S_IDLE;
   logic signed [CNT_W-1:0]  r_depth = '0;
   logic                     r_err   = 1'b0;

   logic [7:0]              w_ch;
   logic                    w_space;
   logic signed [CNT_W-1:0] w_depth_inc;
   logic signed [CNT_W-1:0] w_depth_dec;

   always_comb begin
      w_ch = in;
      if (in >= 8'h41 && in <= 8'h5A) begin
         w_ch = in | 8'h20;
      end
   end

   assign w_space     = (in == 8'h20);
   assign w_depth_inc = (r_depth == DEPTH_MAX) ? r_depth : r_depth + DEPTH_ONE;
   assign w_depth_dec = (r_depth == DEPTH_MIN) ? r_depth : r_depth - DEPTH_ONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_depth <= '0;
         r_err   <= 1'b0;
      end else if (w_space) begin
         r_state <= S_IDLE;
         // A completed "end" that leaves depth negative is a confirmed error.
         if (r_state == S_END && r_depth[CNT_W-1]) begin
            r_err <= 1'b1;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_ch == "b")      r_state <= S_B;
               else if (w_ch == "e") r_state <= S_E;
               else                  r_state <= S_OTHER;
            end
            S_B:    r_state <= (w_ch == "e") ? S_BE   : S_OTHER;
            S_BE:   r_state <= (w_ch == "g") ? S_BEG  : S_OTHER;
            S_BEG:  r_state <= (w_ch == "i") ? S_BEGI : S_OTHER;
            S_BEGI: begin
               if (w_ch == "n") begin
                  r_state <= S_BEGIN;
                  r_depth <= w_depth_inc;
               end else begin
                  r_state <= S_OTHER;
               end
            end
            S_BEGIN: begin
               r_state <= S_OTHER;
               r_depth <= w_depth_dec;
            end
            S_E:    r_state <= (w_ch == "n") ? S_EN : S_OTHER;
            S_EN: begin
               if (w_ch == "d") begin
                  r_state <= S_END;
                  r_depth <= w_depth_dec;
               end else begin
                  r_state <= S_OTHER;
               end
            end
            S_END: begin
               r_state <= S_OTHER;
               r_depth <= w_depth_inc;
            end
            default: r_state <= S_OTHER;
         endcase
      end
   end

   assign result = (r_depth == '0) && !r_err;

endmodule

// File: tb/tb_block_checker.sv
// Directed bench for block_checker: each driven byte pushes its expected result
// onto a queue, which is popped and checked one cycle later.
module tb_block_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in = 8'h20;
   logic       result;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   bit          exp_q[$];

   block_checker #(.CNT_W(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .in     (in),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input bit e);
      n_checks++;
      assert (result === e) begin
         n_pass++;
      end else begin
         $error("FAIL %s result=%b expected=%b", tag, result, e);
      end
   endtask

   task automatic step(input logic [7:0] ch, input logic rst, input bit e, input string tag);
      @(negedge clk);
      in    = ch;
      reset = rst;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check(tag, exp_q.pop_front());
   endtask

   task automatic feed(input string tag, input string s, input string ex);
      for (int i = 0; i < s.len(); i++) begin
         step(s[i], 1'b0, ex[i] == "1", $sformatf("%s[%0d]", tag, i));
      end
   endtask

   task automatic do_reset(input string tag);
      step("b", 1'b1, 1'b1, tag);
   endtask

   initial begin
      #1;
      check("powerup", 1'b1);

      // No reset yet: power-up state must behave as reset state.
      feed("cancel_end", "a BEgIn Endc end BEgIn", "1111110000100001111110");

      do_reset("reset1");
      feed("idle", "   ", "111");

      feed("cancel_begin", "beginx ", "1111011");

      feed("sticky", "end begin end ", "11000000000000");
      do_reset("reset2");
      feed("after_sticky", " ", "1");

      feed("nest", "begin begin end end ", "11110000000000000011");

      // Depth saturates at +3 for CNT_W=3, so three ends rebalance four begins.
      feed("sat", "begin begin begin begin end end end ",
           "111100000000000000000000000000000011");

      do_reset("reset3");
      feed("midword", "begi", "1111");
      do_reset("reset_mid");
      feed("after_mid", "n ", "11");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog result=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/block_checker.md
Name: block_checker

Overview:
- Streaming checker for ASCII text, one character per clock.
- Tracks "begin"/"end" keyword nesting, case-insensitive; words are maximal runs of non-space characters.
- `result` is asserted while the text seen so far is balanced and no unmatched "end" has ever been confirmed.
- Sits behind a byte-serial character source; pure monitor with no backpressure.

Parameters:
- CNT_W, default 32: width of the nesting-depth counter, two's-complement signed.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- in  input  8  ASCII character sampled on every rising edge; 0x20 = space.
- result  output  1  1 = balanced and legal so far; combinational from registered state only.

Behaviour:
- Reset state and power-up state are identical: word FSM = IDLE, depth = 0, err = 0, so result = 1. Registers carry initial values; a bench that never asserts reset still sees defined output.
- Reset has priority over `in` on the same edge.
- Case folding: bytes 'A'..'Z' map to 'a'..'z' before comparison. All other bytes compare unchanged.
- Word FSM states: IDLE, B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER.
- Any state, in = space: next = IDLE (word terminated).
  - If the current state is END and depth < 0 after this word, set err = 1. err is sticky until reset.
- Consecutive spaces stay in IDLE.
- IDLE: 'b' -> B; 'e' -> E; any other non-space -> OTHER.
- Begin chain: B + 'e' -> BE; BE + 'g' -> BEG; BEG + 'i' -> BEGI; BEGI + 'n' -> BEGIN, depth += 1 (tentative).
- End chain: E + 'n' -> EN; EN + 'd' -> END, depth -= 1 (tentative).
- BEGIN + non-space -> OTHER, depth -= 1 (cancels; word is e.g. "beginx").
- END + non-space -> OTHER, depth += 1 (cancels; word is e.g. "endc").
- Any mismatch inside a chain -> OTHER. OTHER + non-space -> OTHER.
- Tentative counts are visible at once: the cycle after 'n' of "begin", result reflects the incremented depth.
- result = (depth == 0) && !err. Negative depth gives result 0 even before it is confirmed.
- Latency: one clock. `in` is sampled at a rising edge, and result reflects it after that edge.
- Confirmed error, e.g. "end begin": after the space following "end", err = 1, and result stays 0 permanently until reset regardless of later begins.
- Counter bounds: the counter saturates at its signed max/min and never wraps.
- Non-ASCII bytes (>= 0x80) and control characters count as ordinary non-space characters.
- Prefixes such as "beg" or "en" followed by space have no effect on depth.

Test Plan:
- Reset then idle: assert reset one cycle, then feed spaces -> result = 1 throughout.
- Mixed-case stream "a BEgIn End" -> result 0 after 'n' of BEgIn, 1 after 'd' of End.
- Cancelled "end": continue the previous stream with "c end BEgIn", i.e. full stream "a BEgIn Endc end BEgIn" (no reset asserted).
  - result goes 0 at 'c' (Endc cancelled, depth 1).
  - 1 after 'd' of "end".
  - 0 after final 'n'.
  - A bench that never asserts reset sees the same values.
- Cancelled "begin": "beginx " -> result 1 before 'n', 0 after 'n', 1 after 'x', remains 1.
- Sticky error: "end begin end " -> result 0 after first 'd'; err latched at the following space; result stays 0 through the rest of the stream, including after the final "end"; reset restores result = 1.
- Nesting: "begin begin end end " -> depth 1, 2, 1, 0; result 1 only at start and after final 'd'.
- Reset mid-word: after "begi", assert reset -> result 1 next cycle; subsequent "n " alone leaves result 1.
